// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: opcode encodings,
// controller FSM states and the divide-by-zero result value.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_NOT_A = 4'd6;
    localparam logic [3:0] OP_NOT_B = 4'd7;
    localparam logic [3:0] OP_SQ_A  = 4'd8;
    localparam logic [3:0] OP_SQ_B  = 4'd9;
    localparam logic [3:0] OP_LT    = 4'd10;
    localparam logic [3:0] OP_EQ    = 4'd11;
    localparam logic [3:0] OP_GT    = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DIV  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [15:0] DZ_RESULT = 16'h00FF;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between two ALU requesters, the response consumer
// and the shared-ALU controller.
interface alu_share_ctrl_if;

    // Every channel transfers on a rising edge where valid & ready are both
    // high; the source holds valid and payload stable until that edge.
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_op;
    logic [7:0] req0_a;
    logic [7:0] req0_b;

    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_op;
    logic [7:0] req1_a;
    logic [7:0] req1_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_dz;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_dz,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_dz,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_div8_seq.sv
// 8-bit restoring divider: loads on i_start, then produces one quotient bit
// per cycle MSB first; o_done/o_quotient are valid in the 8th iteration cycle.
module alu_div8_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_dividend,
    input  logic [7:0] i_divisor,
    output logic       o_done,
    output logic [7:0] o_quotient
);

    logic       r_active;
    logic [2:0] r_cnt;
    logic [7:0] r_rem;
    logic [7:0] r_quot;
    logic [7:0] r_divisor;

    logic [8:0] w_trial;
    logic [8:0] w_sub;
    logic       w_bit;
    logic [7:0] w_rem_next;
    logic [7:0] w_quot_next;

    // 9-bit partial remainder; a set MSB already exceeds any 8-bit divisor,
    // otherwise the 9-bit difference sign tells whether subtraction fits.
    assign w_trial     = {r_rem, r_quot[7]};
    assign w_sub       = w_trial - {1'b0, r_divisor};
    assign w_bit       = w_trial[8] | ~w_sub[8];
    assign w_rem_next  = w_bit ? w_sub[7:0] : w_trial[7:0];
    assign w_quot_next = {r_quot[6:0], w_bit};

    assign o_done     = r_active && (r_cnt == 3'd7);
    assign o_quotient = w_quot_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_cnt     <= 3'd0;
            r_rem     <= 8'h00;
            r_quot    <= 8'h00;
            r_divisor <= 8'h00;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_cnt     <= 3'd0;
            r_rem     <= 8'h00;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
        end else if (r_active) begin
            r_rem  <= w_rem_next;
            r_quot <= w_quot_next;
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one 8-bit ALU between two
// requesters; results return on a single id-tagged response channel.
module alu_share_ctrl
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu_share_ctrl_if.slave    bus,
    output logic               busy,
    output state_t             o_dbg_state
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ptr;
    logic        r_id;
    logic [3:0]  r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_result;
    logic        r_dz;

    logic        w_idle;
    logic        w_any;
    logic        w_gnt_id;
    logic        w_accept;
    logic [3:0]  w_op;
    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic        w_is_div;
    logic        w_b_zero;
    logic        w_div_start;
    logic        w_div_done;
    logic [7:0]  w_quot;
    logic [15:0] w_alu;

    // Readies depend only on state, pointer and valids; rst_n gates them
    // so nothing is offered while reset is held.
    assign w_idle   = (r_state == IDLE) && rst_n;
    assign w_any    = bus.req0_valid | bus.req1_valid;
    assign w_gnt_id = (bus.req0_valid && bus.req1_valid) ? r_ptr : bus.req1_valid;
    assign w_accept = w_idle && w_any;

    assign bus.req0_ready = w_idle && bus.req0_valid && !w_gnt_id;
    assign bus.req1_ready = w_idle && bus.req1_valid &&  w_gnt_id;

    assign w_op        = w_gnt_id ? bus.req1_op : bus.req0_op;
    assign w_a         = w_gnt_id ? bus.req1_a  : bus.req0_a;
    assign w_b         = w_gnt_id ? bus.req1_b  : bus.req0_b;
    assign w_is_div    = (w_op == OP_DIV);
    assign w_b_zero    = (w_b == 8'h00);
    assign w_div_start = w_accept && w_is_div && !w_b_zero;

    alu_div8_seq u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_a),
        .i_divisor  (w_b),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_comb begin
        w_alu = 16'h0000;
        case (r_op)
            OP_ADD:   w_alu = {8'h00, r_a} + {8'h00, r_b};
            OP_SUB:   w_alu = {8'h00, r_a} - {8'h00, r_b};
            OP_MUL:   w_alu = {8'h00, r_a} * {8'h00, r_b};
            OP_AND:   w_alu = {8'h00, r_a & r_b};
            OP_OR:    w_alu = {8'h00, r_a | r_b};
            OP_NOT_A: w_alu = ~{8'h00, r_a};
            OP_NOT_B: w_alu = ~{8'h00, r_b};
            OP_SQ_A:  w_alu = {8'h00, r_a} * {8'h00, r_a};
            OP_SQ_B:  w_alu = {8'h00, r_b} * {8'h00, r_b};
            OP_LT:    w_alu = (r_a <  r_b) ? 16'hFFFF : 16'h0000;
            OP_EQ:    w_alu = (r_a == r_b) ? 16'hFFFF : 16'h0000;
            OP_GT:    w_alu = (r_a >  r_b) ? 16'hFFFF : 16'h0000;
            default:  w_alu = 16'h0000;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_is_div)    w_state_next = EXEC;
                    else if (w_b_zero) w_state_next = RESP;
                    else              w_state_next = DIV;
                end
            end
            EXEC:    w_state_next = RESP;
            DIV:     if (w_div_done) w_state_next = RESP;
            RESP:    if (bus.rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= 1'b0;
            r_id     <= 1'b0;
            r_op     <= 4'h0;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_result <= 16'h0000;
            r_dz     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr <= ~w_gnt_id;
                r_id  <= w_gnt_id;
                r_op  <= w_op;
                r_a   <= w_a;
                r_b   <= w_b;
                if (w_is_div && w_b_zero) begin
                    r_result <= DZ_RESULT;
                    r_dz     <= 1'b1;
                end
            end
            if (r_state == EXEC) begin
                r_result <= w_alu;
                r_dz     <= 1'b0;
            end
            if ((r_state == DIV) && w_div_done) begin
                r_result <= {8'h00, w_quot};
                r_dz     <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;
    assign bus.rsp_dz     = r_dz;
    assign busy           = (r_state != IDLE);
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level latency/result model.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic        id;
        logic        dz;
        int          lat;
    } obs_t;

    logic clk;
    logic rst_n;
    logic busy;
    state_t dbg_state;

    logic       req_v[2];
    logic [3:0] req_op[2];
    logic [7:0] req_a[2];
    logic [7:0] req_b[2];
    logic       rsp_rdy;
    logic       rnd_on;

    int n_cmp;
    int n_bad;
    int cyc;

    // model state
    logic        m_busy;
    logic        m_rsp;
    logic        m_ptr;
    int          m_cnt;
    logic [17:0] exp_q[$];

    obs_t obs_q[$];
    int   gnt_q[$];

    alu_share_ctrl_if bus ();

    assign bus.req0_valid = req_v[0];
    assign bus.req0_op    = req_op[0];
    assign bus.req0_a     = req_a[0];
    assign bus.req0_b     = req_b[0];
    assign bus.req1_valid = req_v[1];
    assign bus.req1_op    = req_op[1];
    assign bus.req1_a     = req_a[1];
    assign bus.req1_b     = req_b[1];
    assign bus.rsp_ready  = rsp_rdy;

    alu_share_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_res(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        int r;
        ia = a;
        ib = b;
        case (op)
            4'd0:    r = ia + ib;
            4'd1:    r = ia - ib;
            4'd2:    r = ia * ib;
            4'd3:    r = (ib == 0) ? 255 : ia / ib;
            4'd4:    r = ia & ib;
            4'd5:    r = ia | ib;
            4'd6:    r = ~ia;
            4'd7:    r = ~ib;
            4'd8:    r = ia * ia;
            4'd9:    r = ib * ib;
            4'd10:   r = (ia < ib) ? -1 : 0;
            4'd11:   r = (ia == ib) ? -1 : 0;
            4'd12:   r = (ia > ib) ? -1 : 0;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [7:0] b);
        if (op == 4'd3) return (b == 8'h00) ? 1 : 9;
        return 2;
    endfunction

    function automatic logic exp_ready(input int i);
        if (m_busy || !req_v[i]) return 1'b0;
        if (i == 0) return !req_v[1] || (m_ptr == 1'b0);
        return !req_v[0] || (m_ptr == 1'b1);
    endfunction

    // Model + per-cycle compare: check at negedge, advance model at posedge.
    initial begin
        logic [17:0] e;
        int          gid;
        m_busy = 1'b0; m_rsp = 1'b0; m_ptr = 1'b0; m_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 1'b0; m_rsp = 1'b0; m_ptr = 1'b0; m_cnt = 0;
                exp_q.delete();
                check("rst_rsp_valid",  bus.rsp_valid,  0);
                check("rst_rsp_id",     bus.rsp_id,     0);
                check("rst_rsp_dz",     bus.rsp_dz,     0);
                check("rst_rsp_result", bus.rsp_result, 0);
                check("rst_busy",       busy,           0);
                check("rst_ready0",     bus.req0_ready, 0);
                check("rst_ready1",     bus.req1_ready, 0);
            end else begin
                check("rsp_valid", bus.rsp_valid, m_rsp);
                check("busy", busy, m_busy);
                if (m_rsp && exp_q.size() > 0) begin
                    e = exp_q[0];
                    check("rsp_id",     bus.rsp_id,     e[17]);
                    check("rsp_dz",     bus.rsp_dz,     e[16]);
                    check("rsp_result", bus.rsp_result, e[15:0]);
                end
                if (m_busy || req_v[0]) check("ready0", bus.req0_ready, exp_ready(0));
                if (m_busy || req_v[1]) check("ready1", bus.req1_ready, exp_ready(1));
            end
            @(posedge clk);
            if (rst_n) begin
                if (!m_busy) begin
                    if (req_v[0] || req_v[1]) begin
                        gid   = (req_v[0] && req_v[1]) ? int'(m_ptr) : (req_v[1] ? 1 : 0);
                        m_ptr = (gid == 0);
                        exp_q.push_back({gid[0], (req_op[gid] == 4'd3) && (req_b[gid] == 8'h00),
                                         model_res(req_op[gid], req_a[gid], req_b[gid])});
                        m_cnt  = model_lat(req_op[gid], req_b[gid]) - 1;
                        m_rsp  = (m_cnt == 0);
                        m_busy = 1'b1;
                    end
                end else if (!m_rsp) begin
                    m_cnt--;
                    if (m_cnt == 0) m_rsp = 1'b1;
                end else if (rsp_rdy) begin
                    m_busy = 1'b0;
                    m_rsp  = 1'b0;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Monitor: grant order, consumed responses and accept-to-valid latency.
    initial begin
        logic prev_v;
        int   acc_edge;
        int   cur_lat;
        prev_v = 1'b0; acc_edge = 0; cur_lat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (bus.rsp_valid && !prev_v) cur_lat = cyc + 1 - acc_edge;
                if (bus.rsp_valid && rsp_rdy)
                    obs_q.push_back('{res: bus.rsp_result, id: bus.rsp_id, dz: bus.rsp_dz, lat: cur_lat});
                if (bus.req0_ready && req_v[0]) begin
                    acc_edge = cyc + 1;
                    gnt_q.push_back(0);
                end else if (bus.req1_ready && req_v[1]) begin
                    acc_edge = cyc + 1;
                    gnt_q.push_back(1);
                end
                prev_v = bus.rsp_valid;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) rsp_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int t;
        req_v[id] = 1'b1; req_op[id] = op; req_a[id] = a; req_b[id] = b;
        t = 0;
        forever begin
            @(negedge clk);
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) break;
            t++;
            if (t > 500) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: requester %0d never accepted", id);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_v[id] = 1'b0;
        req_op[id] = 4'($urandom); req_a[id] = 8'($urandom); req_b[id] = 8'($urandom);
    endtask

    task automatic wait_rsp(output obs_t o);
        int t;
        t = 0;
        while (obs_q.size() == 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (obs_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: no response within 300 cycles");
            o = '{res: 16'h0, id: 1'b0, dz: 1'b0, lat: 0};
        end else begin
            o = obs_q.pop_front();
        end
    endtask

    task automatic rand_req(input int id, input int n);
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 4'd3;
            a = 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            send(id, op, a, b);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        obs_t o;
        n_cmp = 0; n_bad = 0; rnd_on = 1'b0;
        rst_n = 1'b0; rsp_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b1; req_op[i] = 4'd0; req_a[i] = 8'h11; req_b[i] = 8'h22;
        end

        // model pins
        check("model_add",  model_res(4'd0, 8'd200, 8'd100), 16'h012C);
        check("model_sub",  model_res(4'd1, 8'd1,   8'd2),   16'hFFFF);
        check("model_div",  model_res(4'd3, 8'd250, 8'd7),   16'h0023);
        check("model_mul",  model_res(4'd2, 8'd255, 8'd255), 16'hFE01);
        check("model_nota", model_res(4'd6, 8'h0F,  8'h00),  16'hFFF0);

        // reset with valids held high
        repeat (3) step();
        check("rst_state", dbg_state, IDLE);
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        step();
        rst_n = 1'b1;

        // single ops
        rsp_rdy = 1'b1;
        send(0, 4'd0, 8'd200, 8'd100);
        wait_rsp(o);
        check("add_res", o.res, 16'h012C); check("add_id", o.id, 0);
        check("add_dz", o.dz, 0);          check("add_lat", o.lat, 2);
        step();
        send(0, 4'd1, 8'd1, 8'd2);
        wait_rsp(o);
        check("sub_res", o.res, 16'hFFFF); check("sub_lat", o.lat, 2);
        step();

        // divide and divide by zero
        send(1, 4'd3, 8'd250, 8'd7);
        wait_rsp(o);
        check("div_res", o.res, 16'h0023); check("div_id", o.id, 1);
        check("div_dz", o.dz, 0);          check("div_lat", o.lat, 9);
        step();
        send(1, 4'd3, 8'd5, 8'd0);
        wait_rsp(o);
        check("dz_res", o.res, 16'h00FF); check("dz_flag", o.dz, 1);
        check("dz_lat", o.lat, 1);
        step();

        // contention: both requesters continuously valid
        gnt_q.delete();
        fork
            begin send(0, 4'd0, 8'd10, 8'd20); send(0, 4'd4, 8'hF0, 8'h3C); end
            begin send(1, 4'd2, 8'd3,  8'd4);  send(1, 4'd11, 8'd9, 8'd9); end
        join
        for (int k = 0; k < 4; k++) begin
            wait_rsp(o);
            check("cont_rsp_id", o.id, k % 2);
        end
        check("cont_gnt_cnt", gnt_q.size(), 4);
        for (int k = 0; k < 4 && k < gnt_q.size(); k++) check("cont_gnt", gnt_q[k], k % 2);
        step();

        // backpressure
        rsp_rdy = 1'b0;
        send(0, 4'd9, 8'd0, 8'd16);
        fork send(1, 4'd5, 8'hF0, 8'h0F); join_none
        repeat (8) step();
        check("bp_no_consume", obs_q.size(), 0);
        check("bp_ready1", bus.req1_ready, 0);
        check("bp_valid", bus.rsp_valid, 1);
        rsp_rdy = 1'b1;
        wait_rsp(o);
        check("bp_res", o.res, 16'h0100);
        wait_rsp(o);
        check("bp_next_res", o.res, 16'h00FF); check("bp_next_id", o.id, 1);
        step();

        // randomized traffic
        rnd_on = 1'b1;
        fork
            rand_req(0, 60);
            rand_req(1, 60);
        join
        rnd_on = 1'b0;
        rsp_rdy = 1'b1;
        repeat (30) step();
        obs_q.delete();

        // reset in the middle of a divide
        send(1, 4'd3, 8'd200, 8'd3);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", bus.rsp_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_state", dbg_state, IDLE);
        repeat (2) step();
        rst_n = 1'b1;
        send(0, 4'd2, 8'd255, 8'd255);
        wait_rsp(o);
        check("mrst_mul_res", o.res, 16'hFE01); check("mrst_mul_id", o.id, 0);
        check("mrst_mul_lat", o.lat, 2);
        repeat (15) step();
        check("mrst_no_stale", obs_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester arbiter and sequencer for the shared 8-bit ALU datapath. It accepts operation requests from two independent masters over valid/ready, grants the datapath round-robin, and executes the single-cycle opcodes directly. Divide is replaced by an 8-cycle sequential restoring divider instead of a combinational one. Results return on one shared response channel tagged with the requester id, held until consumed.

## Interface
Parameters: none; opcode encoding is fixed by the shared package.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_op  in  4  opcode, requester 0
- req0_a  in  8  operand 1, requester 0
- req0_b  in  8  operand 2, requester 0
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result when valid&ready
- rsp_id  out  1  requester that issued the result
- rsp_result  out  16  operation result
- rsp_dz  out  1  divide-by-zero flag for this result
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes (a=operand 1, b=operand 2, 16-bit result):
  - 0 add: a+b
  - 1 sub: a−b, 16-bit two's-complement wrap
  - 2 mul: a*b
  - 3 div: {8'h00, a/b}
  - 4 and: a&b, zero-extended
  - 5 or: a|b, zero-extended
  - 6 not_a: ~{8'h00,a}
  - 7 not_b: ~{8'h00,b}
  - 8 sq_a: a*a
  - 9 sq_b: b*b
  - 10 lt: a<b ? FFFF : 0000
  - 11 eq: a==b ? FFFF : 0000
  - 12 gt: a>b ? FFFF : 0000
  - 13–15: 0000
- All comparisons are unsigned.
- Divide by zero: result 16'h00FF, rsp_dz=1. rsp_dz=0 for every other result.
- FSM states and transitions:
  - IDLE: reqN_ready is high only here, and only for the granted requester.
  - IDLE → EXEC on accept of a non-divide opcode.
  - IDLE → DIV on accept of opcode 3 with b≠0.
  - IDLE → RESP directly on opcode 3 with b=0, with result 00FF and dz=1.
  - EXEC → RESP after one cycle; the result is registered.
  - DIV: runs 8 restoring iterations, one quotient bit per cycle, MSB first, with a 9-bit partial remainder. After the 8th iteration → RESP.
  - RESP: rsp_valid=1; all response outputs are stable. RESP → IDLE on rsp_ready.
- Arbitration:
  - Priority pointer ptr (0/1).
  - Both valid in IDLE: grant req[ptr].
  - One valid: grant that requester.
  - After any accept, ptr ← ~granted id.
  - Operands and opcode are latched at accept; requester inputs are don't-care afterwards.
- Requesters hold valid and payload until ready; the controller never drops a valid request.

## Timing
- Accept at edge N (valid&ready sampled high):
  - Non-divide opcode: rsp_valid high from cycle N+2, i.e. one EXEC cycle then RESP.
  - Divide with b≠0: rsp_valid high from cycle N+9 (8 DIV cycles then RESP).
  - Divide with b=0: rsp_valid high from cycle N+1.
- Consume at edge M (rsp_valid&rsp_ready): IDLE at M+1; next accept no earlier than edge M+1.
- Maximum throughput: one non-divide op per 3 cycles when rsp_ready is held high.
- reqN_ready is combinational from state and ptr/valid only. It must not depend on rsp_ready.
- Reset (asynchronous, any state including mid-DIV or RESP):
  - State → IDLE; ptr → 0.
  - rsp_valid, rsp_id, rsp_dz, busy → 0; rsp_result → 16'h0000.
  - req0_ready and req1_ready → 0 while rst_n is low.
  - The in-flight operation is discarded with no response.
- First accept is possible on the first rising edge after rst_n deasserts.

## Structure
- Shared package alu_pkg holds:
  - the opcode localparams (OP_ADD … OP_GT, values 0–12)
  - the FSM state enum (IDLE, EXEC, DIV, RESP)
  - the divide-by-zero result constant 16'h00FF
- Sub-module alu_div8_seq: start pulse, 8-bit dividend/divisor, done pulse, 8-bit quotient; 8-cycle restoring divider.
- The combinational non-divide opcode decode stays inline in the controller.

## Test plan
- Reset: check every output value.
- Single op: req0 op=0, a=200, b=100 → rsp_valid at N+2, result 0x012C, id=0, dz=0. Then op=1, a=1, b=2 → 0xFFFF.
- Divide: req1 op=3, a=250, b=7 → 8 DIV cycles, rsp_valid at N+9, result 0x0023, id=1. Then a=5, b=0 → rsp_valid at N+1, result 0x00FF, dz=1.
- Contention: both valid continuously, rsp_ready=1 → grant order 0,1,0,1. Each requester's payload is held unchanged until its ready.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → result, id and dz stable; no readies asserted; a new accept only after consume.
- Reset mid-DIV: assert rst_n low at iteration 4 → immediate IDLE, rsp_valid=0. After release, op=2, a=255, b=255 → 0xFE01, and no stale divide response appears.
